// File: rtl/arm_pipe_skeleton.sv
`default_nettype none
// ============================================================================
// Module      : arm_pipe_skeleton
// Description : In-order pipeline backbone: fetch PC plus STAGES registers
//               carrying valid/PC/instruction, with freeze, redirect and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_pipe_skeleton #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                STAGES      = 4,
    parameter int                FLUSH_DEPTH = 2,
    parameter logic [ADDR_W-1:0] PC_STEP     = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDR_W-1:0]          branch_addr,
    input  logic [DATA_W-1:0]          instr_in,
    output logic [ADDR_W-1:0]          pc_out,
    output logic [STAGES-1:0]          stg_valid,
    output logic [STAGES*ADDR_W-1:0]   stg_pc,
    output logic [STAGES*DATA_W-1:0]   stg_instr,
    output logic                       wb_valid,
    output logic [ADDR_W-1:0]          wb_pc,
    output logic [DATA_W-1:0]          wb_instr,
    output logic [31:0]                retired_count
);

    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("arm_pipe_skeleton: STAGES must be in 2..8");
        end
        if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES - 1) begin : g_bad_flush
            $error("arm_pipe_skeleton: FLUSH_DEPTH must be in 1..STAGES-1");
        end
    endgenerate

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [STAGES-1:0] r_valid;
    logic [ADDR_W-1:0] r_stg_pc    [STAGES];
    logic [DATA_W-1:0] r_stg_instr [STAGES];
    logic [31:0]       r_retired;

    assign w_pc_inc = r_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= branch_addr;
        end else if (!freeze) begin
            r_pc <= w_pc_inc;
        end
    end

    // Stage 1 records PC+step of the fetch; a branch overrides the freeze hold.
    // Stage index k (0-based) is killed when it lies inside the flush window,
    // or is stage 2 receiving the freeze bubble.
    always_ff @(posedge clk) begin
        if (rst || branch_taken) begin
            r_valid[0]     <= 1'b0;
            r_stg_pc[0]    <= '0;
            r_stg_instr[0] <= '0;
        end else if (!freeze) begin
            r_valid[0]     <= 1'b1;
            r_stg_pc[0]    <= w_pc_inc;
            r_stg_instr[0] <= instr_in;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rst || (branch_taken && (k < FLUSH_DEPTH)) ||
                (freeze && !branch_taken && (k == 1))) begin
                r_valid[k]     <= 1'b0;
                r_stg_pc[k]    <= '0;
                r_stg_instr[k] <= '0;
            end else begin
                r_valid[k]     <= r_valid[k-1];
                r_stg_pc[k]    <= r_stg_pc[k-1];
                r_stg_instr[k] <= r_stg_instr[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (r_valid[STAGES-1]) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_flat
            assign stg_pc[gi*ADDR_W +: ADDR_W]    = r_stg_pc[gi];
            assign stg_instr[gi*DATA_W +: DATA_W] = r_stg_instr[gi];
        end
    endgenerate

    assign pc_out        = r_pc;
    assign stg_valid     = r_valid;
    assign wb_valid      = r_valid[STAGES-1];
    assign wb_pc         = r_stg_pc[STAGES-1];
    assign wb_instr      = r_stg_instr[STAGES-1];
    assign retired_count = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_arm_pipe_skeleton.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_pipe_skeleton
// Description : Scoreboard bench for a 4-stage and a 2-stage pipeline instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_pipe_skeleton;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;

    logic [31:0]  pc0, pc1, instr0, instr1, wbpc0, wbpc1, wbi0, wbi1, cnt0, cnt1;
    logic [3:0]   val0;
    logic [1:0]   val1;
    logic [127:0] spc0, sins0;
    logic [63:0]  spc1, sins1;
    logic         wbv0, wbv1;

    assign instr0 = pc0 ^ 32'hA5A5_0000;
    assign instr1 = pc1 ^ 32'hA5A5_0000;

    arm_pipe_skeleton #(.STAGES(4), .FLUSH_DEPTH(2)) u_dut4 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .instr_in(instr0), .pc_out(pc0),
        .stg_valid(val0), .stg_pc(spc0), .stg_instr(sins0), .wb_valid(wbv0),
        .wb_pc(wbpc0), .wb_instr(wbi0), .retired_count(cnt0)
    );

    arm_pipe_skeleton #(.STAGES(2), .FLUSH_DEPTH(1)) u_dut2 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .instr_in(instr1), .pc_out(pc1),
        .stg_valid(val1), .stg_pc(spc1), .stg_instr(sins1), .wb_valid(wbv1),
        .wb_pc(wbpc1), .wb_instr(wbi1), .retired_count(cnt1)
    );

    typedef struct {
        int          dut;
        int          pos;
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    sb_t         sb[$];
    int          checks = 0;
    int          errors = 0;
    int          st[2]  = '{4, 2};
    int          fd[2]  = '{2, 1};
    logic [31:0] mpc[2];
    logic [31:0] mcnt[2];
    bit          wb_prev[2];

    task automatic check_value(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the expected in-flight positions for the edge about to happen.
    task automatic model_step(input logic r, input logic f, input logic b,
                              input logic [31:0] addr);
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].dut == d) sb.delete(i);
                mpc[d]     = '0;
                mcnt[d]    = '0;
                wb_prev[d] = 1'b0;
            end else begin
                if (wb_prev[d]) mcnt[d] = mcnt[d] + 32'd1;
                wb_prev[d] = 1'b0;
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].dut == d) begin
                        if (b) begin
                            if (sb[i].pos < fd[d]) begin
                                sb.delete(i);
                                continue;
                            end
                            sb[i].pos++;
                        end else if (f) begin
                            if (sb[i].pos >= 2) sb[i].pos++;
                        end else begin
                            sb[i].pos++;
                        end
                        if (sb[i].pos > st[d]) sb.delete(i);
                    end
                end
                if (b) begin
                    mpc[d] = addr;
                end else if (!f) begin
                    sb.push_back('{d, 1, mpc[d] + 32'd4, mpc[d] ^ 32'hA5A5_0000});
                    mpc[d] = mpc[d] + 32'd4;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [255:0] ev, epc, ein, ov, opc, oin;
            int           wi;
            ev = '0; epc = '0; ein = '0; wi = -1;
            foreach (sb[i]) begin
                if (sb[i].dut == d) begin
                    ev[sb[i].pos-1]               = 1'b1;
                    epc[(sb[i].pos-1)*32 +: 32]   = sb[i].pc;
                    ein[(sb[i].pos-1)*32 +: 32]   = sb[i].instr;
                    if (sb[i].pos == st[d]) wi = i;
                end
            end
            ov  = (d == 0) ? 256'(val0)  : 256'(val1);
            opc = (d == 0) ? 256'(spc0)  : 256'(spc1);
            oin = (d == 0) ? 256'(sins0) : 256'(sins1);
            check_value($sformatf("d%0d pc_out", d), (d == 0) ? 256'(pc0) : 256'(pc1), 256'(mpc[d]));
            check_value($sformatf("d%0d stg_valid", d), ov, ev);
            check_value($sformatf("d%0d stg_pc", d), opc, epc);
            check_value($sformatf("d%0d stg_instr", d), oin, ein);
            check_value($sformatf("d%0d retired", d), (d == 0) ? 256'(cnt0) : 256'(cnt1), 256'(mcnt[d]));
            if (wi >= 0) begin
                check_value($sformatf("d%0d wb_valid", d), (d == 0) ? 256'(wbv0) : 256'(wbv1), 256'(1));
                check_value($sformatf("d%0d wb_pc", d), (d == 0) ? 256'(wbpc0) : 256'(wbpc1), 256'(sb[wi].pc));
                check_value($sformatf("d%0d wb_instr", d), (d == 0) ? 256'(wbi0) : 256'(wbi1), 256'(sb[wi].instr));
                sb.delete(wi);
                wb_prev[d] = 1'b1;
            end else begin
                check_value($sformatf("d%0d wb_idle", d),
                            (d == 0) ? {wbv0, wbpc0, wbi0} : {wbv1, wbpc1, wbi1}, 256'(0));
            end
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic b,
                         input logic [31:0] addr);
        rst          = r;
        freeze       = f;
        branch_taken = b;
        branch_addr  = addr;
        model_step(r, f, b, addr);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);          // wb reaches pc 0x4 here
        repeat (2) cycle(0, 1, 0, 0);          // freeze while pc_out = 0x10
        repeat (4) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 32'h100);               // branch from pc_out = 0x20
        repeat (6) cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 32'h200);               // branch overrides freeze
        repeat (6) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);                     // mid-stream reset
        repeat (3) cycle(0, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC);
        end
        repeat (6) cycle(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
